// File: rtl/clkdiv_reset_seq.sv
// clkdiv_reset_seq
//
// Reset sequencer for the divide-by-4 CLKDIV wrapper and the OSER/IDES logic
// behind it. The sequencer waits for a stable PLL lock, holds CLKDIV RESETN low,
// releases it, waits for the divided clock to settle and then releases the
// SERDES reset. If lock is lost or a restart is requested, the whole sequence
// runs again. This keeps CLKDIV and the SERDES leaving reset in a fixed order.
//
// Optional feature macro: CLKDIV_SEQ_LOCK_FILTER_EN
//   When this macro is defined, lock loss in HOLD/SETTLE/RUN is declared only
//   after LOCK_FILTER consecutive low cycles of the synchronized lock.
//   When it is undefined, a single low cycle counts as lock loss.
//
// Ports:
//   hclkin        in   fast serial clock (same net as CLKDIV HCLKIN)
//   reset         in   synchronous, active-high reset
//   pll_lock      in   asynchronous PLL lock, passed through a 2-FF synchronizer
//   restart       in   single-cycle restart request, synchronous to hclkin
//   clkdiv_resetn out  CLKDIV RESETN
//   serdes_reset  out  active-high reset for the OSER/IDES logic
//   ready         out  sequence complete (RUN)
//   state         out  state code: 0 WAIT_LOCK, 1 HOLD, 2 SETTLE, 3 RUN
//   restarts      out  saturating count of lock-loss restarts
module clkdiv_reset_seq #(
  parameter int unsigned LOCK_WAIT   = 16,
  parameter int unsigned RESET_HOLD  = 8,
  parameter int unsigned SETTLE      = 32,
  parameter int unsigned LOCK_FILTER = 4
) (
  input  logic       hclkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       clkdiv_resetn,
  output logic       serdes_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] restarts
);

  localparam int unsigned MAX_AB = (LOCK_WAIT > RESET_HOLD) ? LOCK_WAIT : RESET_HOLD;
  localparam int unsigned MAX_N  = (MAX_AB > SETTLE) ? MAX_AB : SETTLE;
  localparam int unsigned CW     = $clog2(MAX_N) + 1;

  localparam logic [CW-1:0] LW_LAST  = CW'(LOCK_WAIT - 1);
  localparam logic [CW-1:0] RH_LOAD  = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] ST_LOAD  = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    restarts_q, restarts_d;
  logic          lock_meta_q, lock_s_q;
  logic          clkdiv_resetn_q, clkdiv_resetn_d;
  logic          serdes_reset_q, serdes_reset_d;
  logic          ready_q, ready_d;
  logic          lock_s;
  logic          in_active;
  logic          lock_lost;

  assign lock_s    = lock_s_q;
  assign in_active = (state_q != ST_WAIT_LOCK);

`ifdef CLKDIV_SEQ_LOCK_FILTER_EN
  localparam int unsigned FW      = $clog2(LOCK_FILTER) + 1;
  localparam logic [FW-1:0] FL_LAST = FW'(LOCK_FILTER - 1);

  logic [FW-1:0] filt_q, filt_d;

  // filt_q counts the low cycles that came before the current one. Lock loss
  // fires on the LOCK_FILTER-th consecutive low cycle.
  always_comb begin
    filt_d = filt_q;
    if (lock_s) begin
      filt_d = '0;
    end else if (filt_q != FL_LAST) begin
      filt_d = filt_q + 1'b1;
    end
  end

  always_ff @(posedge hclkin) begin
    if (reset) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign lock_lost = in_active && !lock_s && (filt_q == FL_LAST);
`else
  // A single low cycle counts as lock loss. LOCK_FILTER is legal (>=1) by
  // construction, so this term only keeps the parameter referenced here.
  assign lock_lost = in_active && !lock_s && (LOCK_FILTER != 0);
`endif

  // Next-state logic and next-output logic. In WAIT_LOCK, cnt counts up the
  // qualified lock cycles. In HOLD and SETTLE, cnt is loaded on entry and
  // counts down to zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    restarts_d = restarts_q;

    if (lock_lost) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      if (restarts_q != 8'hFF) begin
        restarts_d = restarts_q + 8'd1;
      end
    end else if (restart) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LW_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = RH_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = ST_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // The outputs are decoded from the next state. They change on the same
    // edge as the state transition.
    clkdiv_resetn_d = (state_d == ST_SETTLE) || (state_d == ST_RUN);
    serdes_reset_d  = (state_d != ST_RUN);
    ready_d         = (state_d == ST_RUN);
  end

  always_ff @(posedge hclkin) begin
    if (reset) begin
      state_q         <= ST_WAIT_LOCK;
      cnt_q           <= '0;
      restarts_q      <= '0;
      lock_meta_q     <= 1'b0;
      lock_s_q        <= 1'b0;
      clkdiv_resetn_q <= 1'b0;
      serdes_reset_q  <= 1'b1;
      ready_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      restarts_q      <= restarts_d;
      lock_meta_q     <= pll_lock;
      lock_s_q        <= lock_meta_q;
      clkdiv_resetn_q <= clkdiv_resetn_d;
      serdes_reset_q  <= serdes_reset_d;
      ready_q         <= ready_d;
    end
  end

  assign clkdiv_resetn = clkdiv_resetn_q;
  assign serdes_reset  = serdes_reset_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign restarts      = restarts_q;

endmodule

// File: tb/tb_clkdiv_reset_seq.sv
// Testbench for clkdiv_reset_seq. It uses the default parameters. The
// reference model tracks how long the sequence has run without an abort, and
// gets the state from cumulative thresholds. The same bench also works when
// CLKDIV_SEQ_LOCK_FILTER_EN is defined.
module tb_clkdiv_reset_seq;

  localparam int LW = 16;
  localparam int RH = 8;
  localparam int ST = 32;
`ifdef CLKDIV_SEQ_LOCK_FILTER_EN
  localparam int F = 4;
`else
  localparam int F = 1;
`endif

  logic       hclkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       clkdiv_resetn;
  logic       serdes_reset;
  logic       ready;
  logic [1:0] state;
  logic [7:0] restarts;

  int checks = 0;
  int errors = 0;

  clkdiv_reset_seq #(
    .LOCK_WAIT(LW), .RESET_HOLD(RH), .SETTLE(ST), .LOCK_FILTER(4)
  ) dut (
    .hclkin(hclkin), .reset(reset), .pll_lock(pll_lock), .restart(restart),
    .clkdiv_resetn(clkdiv_resetn), .serdes_reset(serdes_reset), .ready(ready),
    .state(state), .restarts(restarts)
  );

  always #5 hclkin = ~hclkin;

  // Reference model state.
  int run_len = 0;     // edges of uninterrupted progress since last abort
  int low_run = 0;     // consecutive low cycles of synchronized lock
  int m_rs = 0;        // expected restarts
  bit s1 = 0, s2 = 0;  // synchronizer pipeline

  function automatic int m_state();
    if (run_len < LW) return 0;
    if (run_len < LW + RH) return 1;
    if (run_len < LW + RH + ST) return 2;
    return 3;
  endfunction

  task automatic model_edge();
    bit ls;
    if (reset) begin
      run_len = 0; low_run = 0; m_rs = 0; s1 = 0; s2 = 0;
    end else begin
      ls = s2;
      if (ls) low_run = 0;
      else if (low_run < 1000) low_run = low_run + 1;
      if (run_len >= LW) begin
        if (!ls && low_run >= F) begin
          run_len = 0;
          if (m_rs < 255) m_rs = m_rs + 1;
        end else if (restart) begin
          run_len = 0;
        end else if (run_len < LW + RH + ST) begin
          run_len = run_len + 1;
        end
      end else begin
        if (!ls || restart) run_len = 0;
        else run_len = run_len + 1;
      end
      s2 = s1;
      s1 = pll_lock;
    end
  endtask

  task automatic check_out(input string name, input int st, input bit cr,
                           input bit sr, input bit rdy, input int rc);
    checks++;
    if (state !== 2'(st) || clkdiv_resetn !== cr || serdes_reset !== sr ||
        ready !== rdy || restarts !== 8'(rc)) begin
      errors++;
      $display("FAIL %s @%0t: got state=%0d clkdiv_resetn=%0b serdes_reset=%0b ready=%0b restarts=%0d, expected state=%0d clkdiv_resetn=%0b serdes_reset=%0b ready=%0b restarts=%0d",
               name, $time, state, clkdiv_resetn, serdes_reset, ready, restarts,
               st, cr, sr, rdy, rc);
    end
  endtask

  task automatic step();
    int ms;
    @(posedge hclkin);
    model_edge();
    #1;
    ms = m_state();
    check_out("model", ms, ms >= 2, ms != 3, ms == 3, m_rs);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit    rst;
    bit    lock;
    bit    rs;
    int    n;
    int    st;
    bit    cr;
    bit    sr;
    bit    rdy;
    int    rc;
    string name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Power-up, the timing boundaries, and restart pulses in RUN and in SETTLE.
    tbl.push_back('{1, 0, 0, 4,  0, 0, 1, 0, 0, "reset_state"});
    tbl.push_back('{0, 1, 0, 25, 1, 0, 1, 0, 0, "edge25_hold"});
    tbl.push_back('{0, 1, 0, 1,  2, 1, 1, 0, 0, "edge26_resetn_rise"});
    tbl.push_back('{0, 1, 0, 31, 2, 1, 1, 0, 0, "edge57_settle"});
    tbl.push_back('{0, 1, 0, 1,  3, 1, 0, 1, 0, "edge58_ready"});
    tbl.push_back('{0, 1, 0, 10, 3, 1, 0, 1, 0, "run_stays"});
    tbl.push_back('{0, 1, 1, 1,  0, 0, 1, 0, 0, "restart_in_run"});
    tbl.push_back('{0, 1, 0, 15, 0, 0, 1, 0, 0, "requal_15"});
    tbl.push_back('{0, 1, 0, 1,  1, 0, 1, 0, 0, "requal_16_hold"});
    tbl.push_back('{0, 1, 0, 8,  2, 1, 1, 0, 0, "requal_settle"});
    tbl.push_back('{0, 1, 0, 5,  2, 1, 1, 0, 0, "in_settle"});
    tbl.push_back('{0, 1, 1, 1,  0, 0, 1, 0, 0, "restart_in_settle"});
    tbl.push_back('{0, 1, 0, 16, 1, 0, 1, 0, 0, "after_restart_hold"});
    tbl.push_back('{0, 1, 0, 8,  2, 1, 1, 0, 0, "after_restart_settle"});
    tbl.push_back('{0, 1, 0, 32, 3, 1, 0, 1, 0, "after_restart_run"});

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; pll_lock = tbl[i].lock; restart = tbl[i].rs;
      run(tbl[i].n);
      check_out(tbl[i].name, tbl[i].st, tbl[i].cr, tbl[i].sr, tbl[i].rdy, tbl[i].rc);
    end
    restart = 0;

    // Lock loss in RUN: a drop of F cycles is detected F+2 edges after the fall.
    pll_lock = 0; run(F);
    pll_lock = 1; run(1);
    check_out("loss_not_yet", 3, 1, 0, 1, 0);
    run(1);
    check_out("loss_detected", 0, 0, 1, 0, 1);
    run(15);
    check_out("loss_requal_wait", 0, 0, 1, 0, 1);
    run(1);
    check_out("loss_requal_hold", 1, 0, 1, 0, 1);
    run(8 + 32);
    check_out("loss_back_to_run", 3, 1, 0, 1, 1);

`ifdef CLKDIV_SEQ_LOCK_FILTER_EN
    // A drop one cycle shorter than the filter is ignored.
    pll_lock = 0; run(F - 1);
    pll_lock = 1; run(F + 3);
    check_out("filtered_glitch", 3, 1, 0, 1, 1);
`endif

    // Lock loss together with restart counts as lock loss.
    pll_lock = 0; run(F);
    pll_lock = 1; run(1);
    restart = 1; run(1);
    restart = 0;
    check_out("loss_and_restart", 0, 0, 1, 0, 2);

    // Unstable lock: 10 high, 1 low, then high; rise 26 edges after final rise.
    reset = 1; pll_lock = 0; run(2);
    check_out("reset_clears_restarts", 0, 0, 1, 0, 0);
    reset = 0; pll_lock = 1; run(10);
    pll_lock = 0; run(1);
    pll_lock = 1; run(25);
    check_out("unstable_edge25", 1, 0, 1, 0, 0);
    run(1);
    check_out("unstable_edge26", 2, 1, 1, 0, 0);

    // Saturation: 258 lock losses in HOLD.
    for (int k = 0; k < 258; k++) begin
      pll_lock = 1; run(20);
      pll_lock = 0; run(F + 2);
    end
    check_out("saturated", 0, 0, 1, 0, 255);

    // Reset asserted in SETTLE.
    pll_lock = 1; run(31);
    check_out("pre_reset_settle", 2, 1, 1, 0, 255);
    reset = 1; run(1);
    check_out("reset_in_settle", 0, 0, 1, 0, 0);
    reset = 0; run(25);
    check_out("post_reset_edge25", 1, 0, 1, 0, 0);
    run(1);
    check_out("post_reset_edge26", 2, 1, 1, 0, 0);

    // Randomized segments checked against the model on every edge.
    for (int seg = 0; seg < 70; seg++) begin
      int len;
      bit lv;
      lv = ($urandom_range(0, 3) != 0);
      len = lv ? $urandom_range(1, 90) : $urandom_range(1, 6);
      pll_lock = lv;
      for (int k = 0; k < len; k++) begin
        restart = ($urandom_range(0, 79) == 0);
        reset = ($urandom_range(0, 599) == 0);
        step();
      end
    end
    restart = 0; reset = 0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
